// File: rtl/uart_rx_probe.sv
// 8N1 UART receiver for benches: deserializes the DUT's serial Tx line into byte strobes,
// flags bad stop bits, and counts good bytes.
module uart_rx_probe #(
    parameter int CLKS_PER_BIT = 16,
    parameter int COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    output logic [7:0]         data,
    output logic               valid,
    output logic               frame_err,
    output logic               busy,
    output logic [COUNT_W-1:0] byte_count
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_reg;
    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             rx_s;

    assign rx_s = sync_reg[1];
    assign busy = (state_reg != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            sync_reg    <= 2'b11;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            data        <= '0;
            valid       <= 1'b0;
            frame_err   <= 1'b0;
            byte_count  <= '0;
        end else begin
            sync_reg  <= {sync_reg[0], rx};
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_reg <= S_START;
                        cnt_reg   <= '0;
                    end
                end
                S_START: begin
                    // Mid-start-bit recheck rejects short low glitches.
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        cnt_reg   <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= S_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg <= '0;
                        if (rx_s) begin
                            data       <= shift_reg;
                            valid      <= 1'b1;
                            byte_count <= byte_count + 1'b1;
                            state_reg  <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state_reg <= S_BREAK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_BREAK: begin
                    // A held-low line is one error, not a stream of zero frames.
                    if (rx_s) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
